// File: rtl/switch_pulse_seq.sv
// Timed pulse-train sequencer for a photonic switch: optional start delay, then
// n on/off pulses, all timed in 1 us ticks of the shared enable strobe.
module switch_pulse_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_1MHz,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] delay_us,
  input  logic [W-1:0] width_us,
  input  logic [W-1:0] off_us,
  input  logic [W-1:0] n_pulses,
  output logic         switch_out,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] pulse_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_ON,
    S_OFF,
    S_DONE
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] delay_q, delay_d;
  logic [W-1:0] width_q, width_d;
  logic [W-1:0] off_q, off_d;
  logic [W-1:0] n_q, n_d;
  logic [W-1:0] pc_q, pc_d;
  logic         sw_q, sw_d;
  logic         done_q, done_d;

  logic [W-1:0] cur_dur;
  logic [W-1:0] pc_inc;

  always_comb begin
    cur_dur = '0;
    case (state_q)
      S_DELAY: cur_dur = delay_q;
      S_ON:    cur_dur = width_q;
      S_OFF:   cur_dur = off_q;
      default: cur_dur = '0;
    endcase
  end

  assign pc_inc = pc_q + W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    delay_d = delay_q;
    width_d = width_q;
    off_d   = off_q;
    n_d     = n_q;
    pc_d    = pc_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((n_pulses != '0) && (width_us != '0)) begin
            delay_d = delay_us;
            width_d = width_us;
            off_d   = off_us;
            n_d     = n_pulses;
            cnt_d   = '0;
            pc_d    = '0;
            state_d = S_DELAY;
          end else begin
            // Degenerate train: report completion immediately without going busy.
            done_d = 1'b1;
            pc_d   = '0;
          end
        end
      end
      S_DELAY, S_ON, S_OFF: begin
        // Exit is decided on the count alone, so a tick in the exit clk is dropped.
        if (cnt_q == cur_dur) begin
          cnt_d = '0;
          case (state_q)
            S_DELAY: state_d = S_ON;
            S_OFF:   state_d = S_ON;
            default: begin
              pc_d    = pc_inc;
              state_d = (pc_inc == n_q) ? S_DONE : S_OFF;
            end
          endcase
        end else if (en_1MHz) begin
          cnt_d = cnt_q + W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      delay_d = delay_q;
      width_d = width_q;
      off_d   = off_q;
      n_d     = n_q;
      pc_d    = pc_q;
      done_d  = 1'b0;
    end

    done_d = done_d | (state_d == S_DONE);
    sw_d   = (state_d == S_ON);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      delay_q <= '0;
      width_q <= '0;
      off_q   <= '0;
      n_q     <= '0;
      pc_q    <= '0;
      sw_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      delay_q <= delay_d;
      width_q <= width_d;
      off_q   <= off_d;
      n_q     <= n_d;
      pc_q    <= pc_d;
      sw_q    <= sw_d;
      done_q  <= done_d;
    end
  end

  assign switch_out  = sw_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign pulse_count = pc_q;

endmodule

// File: tb/tb_switch_pulse_seq.sv
// Directed bench for switch_pulse_seq: per-clock vector table with fast ticks,
// then a slow-timebase train with config/start disturbance while busy.
module tb_switch_pulse_seq;

  logic       clk = 1'b0;
  logic       reset, en_1MHz, start, abort;
  logic [7:0] delay_us, width_us, off_us, n_pulses;
  logic       switch_out, busy, done;
  logic [7:0] pulse_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  switch_pulse_seq #(.W(8)) dut (
    .clk(clk), .reset(reset), .en_1MHz(en_1MHz), .start(start), .abort(abort),
    .delay_us(delay_us), .width_us(width_us), .off_us(off_us), .n_pulses(n_pulses),
    .switch_out(switch_out), .busy(busy), .done(done), .pulse_count(pulse_count)
  );

  typedef struct {
    logic       rst, st, ab, tk;
    logic [7:0] dly, wid, off, n;
    logic       sw, bsy, dn;
    logic [7:0] pc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rst, st, ab, tk,
                              input logic [7:0] dly, wid, off, n,
                              input logic sw, bsy, dn, input logic [7:0] pc);
    vec_t v;
    v.rst = rst; v.st = st; v.ab = ab; v.tk = tk;
    v.dly = dly; v.wid = wid; v.off = off; v.n = n;
    v.sw = sw; v.bsy = bsy; v.dn = dn; v.pc = pc;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1; en_1MHz = 1'b0; start = 1'b0; abort = 1'b0;
    delay_us = '0; width_us = '0; off_us = '0; n_pulses = '0;

    // rst st ab tk | dly wid off n | sw bsy dn pc   (tick every clk where tk=1)
    vq.push_back(mk(1,0,0,0, 0,0,0,0, 0,0,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,0));
    // delay=1 width=2 off=0 n=2; tick in start clk is ignored
    vq.push_back(mk(0,1,0,1, 1,2,0,2, 0,1,0,0));
    vq.push_back(mk(0,0,0,1, 1,2,0,2, 0,1,0,0));
    vq.push_back(mk(0,0,0,0, 1,2,0,2, 1,1,0,0));
    vq.push_back(mk(0,0,0,1, 1,2,0,2, 1,1,0,0));
    vq.push_back(mk(0,0,0,1, 1,2,0,2, 1,1,0,0));
    vq.push_back(mk(0,0,0,0, 1,2,0,2, 0,1,0,1));
    vq.push_back(mk(0,0,0,0, 1,2,0,2, 1,1,0,1));
    vq.push_back(mk(0,0,0,1, 1,2,0,2, 1,1,0,1));
    vq.push_back(mk(0,0,0,1, 1,2,0,2, 1,1,0,1));
    vq.push_back(mk(0,0,0,1, 1,2,0,2, 0,1,1,2));
    vq.push_back(mk(0,0,0,0, 1,2,0,2, 0,0,0,2));
    // degenerate starts: n=0, then width=0
    vq.push_back(mk(0,1,0,0, 1,2,0,0, 0,0,1,0));
    vq.push_back(mk(0,0,0,0, 1,2,0,0, 0,0,0,0));
    vq.push_back(mk(0,1,0,0, 0,0,0,3, 0,0,1,0));
    // delay=0 width=1 n=1, with start and width change while busy
    vq.push_back(mk(0,1,0,1, 0,1,0,1, 0,1,0,0));
    vq.push_back(mk(0,0,0,0, 0,1,0,1, 1,1,0,0));
    vq.push_back(mk(0,1,0,1, 0,5,0,1, 1,1,0,0));
    vq.push_back(mk(0,0,0,0, 0,5,0,1, 0,1,1,1));
    vq.push_back(mk(0,0,0,0, 0,5,0,1, 0,0,0,1));
    // n=4 train aborted during second ON (abort beats start and tick)
    vq.push_back(mk(0,1,0,0, 0,3,0,4, 0,1,0,0));
    vq.push_back(mk(0,0,0,0, 0,3,0,4, 1,1,0,0));
    vq.push_back(mk(0,0,0,1, 0,3,0,4, 1,1,0,0));
    vq.push_back(mk(0,0,0,1, 0,3,0,4, 1,1,0,0));
    vq.push_back(mk(0,0,0,1, 0,3,0,4, 1,1,0,0));
    vq.push_back(mk(0,0,0,0, 0,3,0,4, 0,1,0,1));
    vq.push_back(mk(0,0,0,0, 0,3,0,4, 1,1,0,1));
    vq.push_back(mk(0,1,1,1, 0,3,0,4, 0,0,0,1));
    vq.push_back(mk(0,0,0,0, 0,3,0,4, 0,0,0,1));
    // reset mid-ON, then a start with a coincident tick (not counted)
    vq.push_back(mk(0,1,0,1, 0,2,0,1, 0,1,0,0));
    vq.push_back(mk(0,0,0,0, 0,2,0,1, 1,1,0,0));
    vq.push_back(mk(1,1,0,1, 0,2,0,1, 0,0,0,0));
    vq.push_back(mk(0,1,0,1, 1,1,0,1, 0,1,0,0));
    vq.push_back(mk(0,0,0,0, 1,1,0,1, 0,1,0,0));
    vq.push_back(mk(0,0,0,1, 1,1,0,1, 0,1,0,0));
    vq.push_back(mk(0,0,0,0, 1,1,0,1, 1,1,0,0));
    vq.push_back(mk(0,0,0,1, 1,1,0,1, 1,1,0,0));
    vq.push_back(mk(0,0,0,0, 1,1,0,1, 0,1,1,1));
    vq.push_back(mk(0,0,0,0, 1,1,0,1, 0,0,0,1));

    @(negedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      reset = vq[i].rst; start = vq[i].st; abort = vq[i].ab; en_1MHz = vq[i].tk;
      delay_us = vq[i].dly; width_us = vq[i].wid; off_us = vq[i].off; n_pulses = vq[i].n;
      @(posedge clk); #1;
      chk("switch_out", i, {7'd0, switch_out}, {7'd0, vq[i].sw});
      chk("busy", i, {7'd0, busy}, {7'd0, vq[i].bsy});
      chk("done", i, {7'd0, done}, {7'd0, vq[i].dn});
      chk("pulse_count", i, pulse_count, vq[i].pc);
      $display("vec %0d: sw=%0b busy=%0b done=%0b pc=%0d", i, switch_out, busy, done, pulse_count);
    end

    // Tick every 8 clks; delay=2 width=3 off=1 n=2. Start at k=0, ticks at k%8==7.
    // ON after edges 16..39 and 48..71, DONE after edge 72, IDLE from 73.
    reset = 1'b0; abort = 1'b0;
    delay_us = 8'd2; off_us = 8'd1; n_pulses = 8'd2;
    for (int k = 0; k < 80; k++) begin
      logic esw, ebsy, edn;
      start    = (k == 0) || ((k % 5 == 3) && (k < 72));
      width_us = (k == 0) ? 8'd3 : 8'($urandom_range(0, 9));
      en_1MHz  = (k % 8 == 7);
      @(posedge clk); #1;
      esw  = ((k >= 16) && (k <= 39)) || ((k >= 48) && (k <= 71));
      ebsy = (k <= 72);
      edn  = (k == 72);
      chk("slow_switch_out", k, {7'd0, switch_out}, {7'd0, esw});
      chk("slow_busy", k, {7'd0, busy}, {7'd0, ebsy});
      chk("slow_done", k, {7'd0, done}, {7'd0, edn});
      if (k == 40) chk("slow_pc_mid", k, pulse_count, 8'd1);
      if (k >= 72) chk("slow_pc_final", k, pulse_count, 8'd2);
    end
    start = 1'b0; en_1MHz = 1'b0;
    $display("slow train: sw/busy/done checked over 80 clks, final pc=%0d", pulse_count);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/switch_pulse_seq.md
SWITCH_PULSE_SEQ -- requirements
Module: switch_pulse_seq

Interface
REQ-001 SHALL provide parameter: W, 8, width of all timing/count fields.
REQ-002 SHALL provide port: clk  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL provide port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port: en_1MHz  input  1  one-clk-wide 1 us timebase tick from the 1 MHz enable generator.
REQ-005 SHALL provide port: start  input  1  request to begin a pulse train; sampled every clk.
REQ-006 SHALL provide port: abort  input  1  terminate any train immediately.
REQ-007 SHALL provide port: delay_us  input  W  ticks from start to first pulse.
REQ-008 SHALL provide port: width_us  input  W  ticks switch held on per pulse.
REQ-009 SHALL provide port: off_us  input  W  ticks switch held off between pulses.
REQ-010 SHALL provide port: n_pulses  input  W  number of pulses in the train.
REQ-011 SHALL provide port: switch_out  output  1  photonic switch drive, 1 = on.
REQ-012 SHALL provide port: busy  output  1  high in any state other than IDLE.
REQ-013 SHALL provide port: done  output  1  one-clk pulse at normal train completion.
REQ-014 SHALL provide port: pulse_count  output  W  pulses completed in the current or last train.

Function
REQ-015 SHALL implement FSM states IDLE, DELAY, ON, OFF, DONE with one tick counter cnt (W bits).
REQ-016 IDLE: on start=1 with n_pulses!=0 and width_us!=0, latch delay/width/off/n, clear cnt and pulse_count, go DELAY next clk.
REQ-017 IDLE: on start=1 with n_pulses==0 or width_us==0, stay IDLE, assert done for exactly one clk, pulse_count cleared to 0.
REQ-018 Config inputs SHALL be used only via latched copies; changes while busy have no effect.
REQ-019 A tick coincident with the accepted start clk SHALL NOT be counted.
REQ-020 DELAY/ON/OFF: each clk, if cnt == latched duration, leave state and clear cnt; else increment cnt on en_1MHz (no tick-based exit).
REQ-021 Durations: DELAY uses delay, ON uses width, OFF uses off; a zero delay/off makes that state last exactly one clk.
REQ-022 DELAY exit -> ON.
REQ-023 ON exit: pulse_count increments; if new pulse_count == latched n -> DONE, else -> OFF.
REQ-024 OFF exit -> ON.
REQ-025 DONE: done=1 for one clk, then IDLE; pulse_count holds its final value until the next accepted start.
REQ-026 switch_out SHALL be registered, 1 exactly in clks where state==ON, else 0.
REQ-027 busy SHALL be 1 in DELAY, ON, OFF, DONE; 0 in IDLE.
REQ-028 start while busy SHALL be ignored.
REQ-029 abort=1 in any state SHALL force IDLE next clk, switch_out=0, done not asserted, pulse_count held; abort has priority over start and tick.
REQ-030 cnt SHALL never wrap; it saturates at the latched duration by construction.

Reset
REQ-031 reset=1 SHALL, on the next rising edge, force IDLE, switch_out=0, busy=0, done=0, pulse_count=0, cnt=0, latched config=0.
REQ-032 reset SHALL take priority over abort, start and en_1MHz, including mid-pulse.

Verification
REQ-033 Tick every 8 clks; start with delay=2,width=3,off=1,n=2 -> switch_out high for two windows each ending one clk after 3rd tick of ON, done one clk after 2nd ON, pulse_count=2.
REQ-034 start with n_pulses=0 -> done one clk, busy stays 0, switch_out stays 0, pulse_count=0.
REQ-035 delay=0,off=0,width=1,n=3 -> DELAY and OFF each one clk, three ON windows, done once, pulse_count=3.
REQ-036 abort during 2nd ON of n=4 train -> switch_out=0 and busy=0 next clk, done never asserted, pulse_count=1.
REQ-037 reset asserted mid-ON -> all outputs 0 next clk; later start with en_1MHz in same clk -> that tick not counted.
REQ-038 Change width_us and pulse start repeatedly while busy -> train timing unchanged, no restart.
